// File: rtl/mem_access_unit.sv
// Load/store front end for a single-port data SRAM: one word access per request,
// byte-lane steering for stores and lane extraction plus extension for loads.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W+1:0] REQ_ADDR,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic        we_r, uns_r;
  logic [1:0]  size_r, lane_r;
  logic        accept, bad;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   store_be = 4'b0001 << lane;
      2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_di(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   store_di = {4{wdata[7:0]}};
      2'b01:   store_di = {2{wdata[15:0]}};
      default: store_di = wdata;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [1:0] size, input logic [1:0] lane,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   format_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   format_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: format_load = word;
    endcase
  endfunction

  assign accept = REQ_VALID && REQ_READY;
  assign bad    = (REQ_SIZE == 2'b11) ||
                  (REQ_SIZE == 2'b01 && REQ_ADDR[0]) ||
                  (REQ_SIZE == 2'b10 && REQ_ADDR[1:0] != 2'b00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = bad ? RESP : ISSUE;
      ISSUE:   next_state = we_r ? RESP : WAIT;
      WAIT:    next_state = RESP;
      default: next_state = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset forces the SRAM idle without a clock.
  always_comb begin
    REQ_READY = (state == IDLE) && !RST;
    RSP_VALID = (state == RESP);
    MEM_CSN   = (state != ISSUE);
    MEM_WEN   = !((state == ISSUE) && we_r);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_r      <= 1'b0;
      uns_r     <= 1'b0;
      size_r    <= 2'b00;
      lane_r    <= 2'b00;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= 32'd0;
      MEM_ADDR  <= '0;
      MEM_BE    <= 4'b0000;
      MEM_DI    <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_r    <= REQ_WE;
          uns_r   <= REQ_UNSIGNED;
          size_r  <= REQ_SIZE;
          lane_r  <= REQ_ADDR[1:0];
          RSP_ERR <= bad;
          // Rejected requests leave the SRAM-facing registers untouched.
          if (!bad) begin
            MEM_ADDR <= REQ_ADDR[ADDR_W+1:2];
            MEM_BE   <= REQ_WE ? store_be(REQ_SIZE, REQ_ADDR[1:0]) : 4'b0000;
            MEM_DI   <= REQ_WE ? store_di(REQ_SIZE, REQ_WDATA) : 32'd0;
          end
        end
        WAIT: RSP_RDATA <= format_load(size_r, lane_r, uns_r, MEM_DOUT);
        RESP: begin
          RSP_RDATA <= 32'd0;
          RSP_ERR   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
